// File: rtl/if_fetch.sv
// Two-wide instruction fetch stage: issues one aligned 64-bit line request at a time
// and pushes the returned instruction(s), tagged with their PCs, into the circular buffer.
module if_fetch #(
  parameter int                 ADDR_W   = 64,
  parameter int                 INST_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fetch_en,
  input  logic                     redirect_en,
  input  logic [ADDR_W-1:0]        redirect_pc,
  output logic                     imem_req,
  output logic [ADDR_W-1:0]        imem_addr,
  input  logic                     imem_ack,
  input  logic                     imem_valid,
  input  logic [2*INST_W-1:0]      imem_data,
  input  logic                     full,
  input  logic                     full_almost,
  output logic                     din1_en,
  output logic                     din2_en,
  output logic [ADDR_W+INST_W-1:0] din1,
  output logic [ADDR_W+INST_W-1:0] din2,
  output logic [ADDR_W-1:0]        pc
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, PUSH} state_e;

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     pc_q, pc_d;
  logic                  drop_q, drop_d;
  logic [2*INST_W-1:0]   data_q, data_d;

  logic [ADDR_W-1:0]     pc_plus4;
  logic                  pushing;

  assign pc_plus4 = pc_q + ADDR_W'(4);
  assign pushing  = (state_q == PUSH);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (!redirect_en && fetch_en && !full && !full_almost)
          state_d = REQ;
      end
      REQ: begin
        if (imem_ack) begin
          state_d = WAIT;
          drop_d  = redirect_en;
        end else if (redirect_en) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        // A response that belongs to a squashed request is consumed and discarded.
        if (imem_valid) begin
          state_d = (drop_q || redirect_en) ? IDLE : PUSH;
          drop_d  = 1'b0;
          data_d  = imem_data;
        end else if (redirect_en) begin
          drop_d  = 1'b1;
        end
      end
      PUSH: begin
        state_d = IDLE;
        pc_d    = pc_q + (pc_q[2] ? ADDR_W'(4) : ADDR_W'(8));
      end
      default: state_d = IDLE;
    endcase
    if (redirect_en)
      pc_d = redirect_pc;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      drop_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
      data_q  <= data_d;
    end
  end

  // Write enables are the only outputs not purely decoded from state: a redirect squashes them.
  always_comb begin
    imem_req  = (state_q == REQ);
    imem_addr = {pc_q[ADDR_W-1:3], 3'b000};
    pc        = pc_q;
    din1_en   = pushing && !redirect_en;
    din2_en   = pushing && !pc_q[2] && !redirect_en;
    din1      = '0;
    din2      = '0;
    if (pushing) begin
      if (pc_q[2]) begin
        din1 = {pc_q, data_q[2*INST_W-1:INST_W]};
      end else begin
        din1 = {pc_q, data_q[INST_W-1:0]};
        din2 = {pc_plus4, data_q[2*INST_W-1:INST_W]};
      end
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed line vectors, multi-cycle corner sequences, then random
// traffic checked against an architectural PC/memory/buffer-occupancy model.
module tb_if_fetch;

  localparam int ADDR_W = 64;
  localparam int INST_W = 32;
  localparam int CAP    = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        fetch_en = 1'b0;
  logic        redirect_en = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic        imem_valid = 1'b0;
  logic [63:0] imem_data = '0;
  logic        full = 1'b0;
  logic        full_almost = 1'b0;
  logic        din1_en, din2_en;
  logic [95:0] din1, din2;
  logic [63:0] pc;

  int checks = 0;
  int errors = 0;

  if_fetch #(.ADDR_W(ADDR_W), .INST_W(INST_W), .RESET_PC(64'h0)) dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en), .redirect_en(redirect_en),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_valid(imem_valid), .imem_data(imem_data),
    .full(full), .full_almost(full_almost), .din1_en(din1_en), .din2_en(din2_en),
    .din1(din1), .din2(din2), .pc(pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        use_redirect;
    logic [63:0] start_pc;
    logic [63:0] line;
    logic [63:0] exp_addr;
    logic        exp_en2;
    logic [95:0] exp_din1;
    logic [95:0] exp_din2;
    logic [63:0] exp_next_pc;
  } vec_t;

  function automatic vec_t mkVec(input logic use_redirect, input logic [63:0] start_pc,
                                 input logic [63:0] line, input logic [63:0] exp_addr,
                                 input logic exp_en2, input logic [95:0] exp_din1,
                                 input logic [95:0] exp_din2, input logic [63:0] exp_next_pc);
    vec_t v;
    v.use_redirect = use_redirect;
    v.start_pc     = start_pc;
    v.line         = line;
    v.exp_addr     = exp_addr;
    v.exp_en2      = exp_en2;
    v.exp_din1     = exp_din1;
    v.exp_din2     = exp_din2;
    v.exp_next_pc  = exp_next_pc;
    return v;
  endfunction

  // Memory contents: a distinct, address-derived word for every 4-byte location.
  function automatic logic [31:0] memWord(input logic [63:0] a);
    return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h5A5A1234;
  endfunction

  function automatic logic [63:0] memLine(input logic [63:0] a);
    return {memWord(a + 64'd4), memWord(a)};
  endfunction

  function automatic logic [63:0] pickPc();
    logic [63:0] r;
    case ($urandom_range(0, 3))
      0:       r = {$urandom, $urandom};
      1:       r = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
      default: r = 64'($urandom_range(0, 4095));
    endcase
    return {r[63:2], 2'b00};
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One complete line fetch from IDLE with same-cycle ack and next-cycle valid.
  task automatic applyStimulus(input vec_t v);
    if (v.use_redirect) begin
      redirect_en = 1'b1;
      redirect_pc = v.start_pc;
      step();
      redirect_en = 1'b0;
      checkOutput("vec_redirect_pc", pc, v.start_pc);
    end
    fetch_en = 1'b1;
    step();
    checkOutput("vec_req", imem_req, 1);
    checkOutput("vec_addr", imem_addr, v.exp_addr);
    imem_ack = 1'b1;
    fetch_en = 1'b0;
    step();
    imem_ack   = 1'b0;
    imem_valid = 1'b1;
    imem_data  = v.line;
    step();
    imem_valid = 1'b0;
    #1;
    checkOutput("vec_din1_en", din1_en, 1);
    checkOutput("vec_din2_en", din2_en, v.exp_en2);
    checkOutput("vec_din1", din1, v.exp_din1);
    checkOutput("vec_din2", din2, v.exp_din2);
    step();
    checkOutput("vec_next_pc", pc, v.exp_next_pc);
    checkOutput("vec_en_pulse", {din1_en, din2_en}, 0);
  endtask

  vec_t        vecs[5];
  logic [63:0] exp_pc;
  logic [63:0] pend_addr;
  logic [63:0] req_addr;
  logic        pending, drain, got1, got2, acked;
  int          occ, lat, pushes;

  initial begin
    vecs[0] = mkVec(0, 64'h0, 64'h11111111_22222222, 64'h0, 1,
                    {64'h0, 32'h22222222}, {64'h4, 32'h11111111}, 64'h8);
    vecs[1] = mkVec(0, 64'h8, 64'h55555555_66666666, 64'h8, 1,
                    {64'h8, 32'h66666666}, {64'hC, 32'h55555555}, 64'h10);
    vecs[2] = mkVec(1, 64'h104, 64'hAAAAAAAA_BBBBBBBB, 64'h100, 0,
                    {64'h104, 32'hAAAAAAAA}, 96'h0, 64'h108);
    vecs[3] = mkVec(1, 64'hFFFF_FFFF_FFFF_FFF8, 64'hDEADBEEF_CAFEF00D, 64'hFFFF_FFFF_FFFF_FFF8, 1,
                    {64'hFFFF_FFFF_FFFF_FFF8, 32'hCAFEF00D},
                    {64'hFFFF_FFFF_FFFF_FFFC, 32'hDEADBEEF}, 64'h0);
    vecs[4] = mkVec(1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h01234567_89ABCDEF, 64'hFFFF_FFFF_FFFF_FFF8, 0,
                    {64'hFFFF_FFFF_FFFF_FFFC, 32'h01234567}, 96'h0, 64'h0);

    repeat (2) @(negedge clk);
    checkOutput("rst_req", imem_req, 0);
    checkOutput("rst_en", {din1_en, din2_en}, 0);
    checkOutput("rst_pc", pc, 0);
    checkOutput("rst_din", {din1, din2}, 0);
    reset = 1'b1;

    $display("[TB] directed line vectors");
    for (int i = 0; i < 5; i++) applyStimulus(vecs[i]);

    $display("[TB] redirect while waiting for a response");
    fetch_en = 1'b1;
    step();
    checkOutput("seqA_req", imem_req, 1);
    imem_ack = 1'b1;
    fetch_en = 1'b0;
    step();
    imem_ack    = 1'b0;
    redirect_en = 1'b1;
    redirect_pc = 64'h200;
    step();
    redirect_en = 1'b0;
    checkOutput("seqA_pc", pc, 64'h200);
    step();
    imem_valid = 1'b1;
    imem_data  = 64'hFFFF0000_EEEE1111;
    #1;
    checkOutput("seqA_drop_en", {din1_en, din2_en}, 0);
    step();
    imem_valid = 1'b0;
    #1;
    checkOutput("seqA_no_push", {din1_en, din2_en}, 0);
    checkOutput("seqA_idle", imem_req, 0);
    applyStimulus(mkVec(0, 64'h200, 64'h77777777_88888888, 64'h200, 1,
                        {64'h200, 32'h88888888}, {64'h204, 32'h77777777}, 64'h208));

    $display("[TB] buffer throttling and abandoned request");
    for (int k = 0; k < 2; k++) begin
      if (k == 0) full_almost = 1'b1;
      else        full = 1'b1;
      fetch_en = 1'b1;
      for (int c = 0; c < 5; c++) begin
        step();
        checkOutput(k == 0 ? "seqB_almost_hold" : "seqB_full_hold", imem_req, 0);
      end
      full_almost = 1'b0;
      full        = 1'b0;
      step();
      checkOutput("seqB_release", imem_req, 1);
      redirect_en = 1'b1;
      redirect_pc = 64'h300;
      fetch_en    = 1'b0;
      step();
      redirect_en = 1'b0;
      checkOutput("seqB_abandon", imem_req, 0);
      checkOutput("seqB_pc", pc, 64'h300);
    end

    $display("[TB] redirect during push");
    fetch_en = 1'b1;
    step();
    imem_ack = 1'b1;
    fetch_en = 1'b0;
    step();
    imem_ack   = 1'b0;
    imem_valid = 1'b1;
    imem_data  = memLine(64'h300);
    step();
    imem_valid  = 1'b0;
    redirect_en = 1'b1;
    redirect_pc = 64'h400;
    #1;
    checkOutput("seqC_squash", {din1_en, din2_en}, 0);
    step();
    redirect_en = 1'b0;
    checkOutput("seqC_pc", pc, 64'h400);
    checkOutput("seqC_idle_en", {din1_en, din2_en}, 0);

    $display("[TB] reset while waiting");
    fetch_en = 1'b1;
    step();
    imem_ack = 1'b1;
    fetch_en = 1'b0;
    step();
    imem_ack = 1'b0;
    #2 reset = 1'b0;
    #1;
    checkOutput("seqD_pc", pc, 0);
    checkOutput("seqD_req", imem_req, 0);
    checkOutput("seqD_en", {din1_en, din2_en}, 0);
    @(negedge clk);
    @(negedge clk);
    reset      = 1'b1;
    imem_valid = 1'b1;
    imem_data  = 64'hBAD0BAD0_BAD1BAD1;
    #1;
    checkOutput("seqD_late_en", {din1_en, din2_en}, 0);
    step();
    imem_valid = 1'b0;
    #1;
    checkOutput("seqD_no_push", {din1_en, din2_en}, 0);
    applyStimulus(mkVec(0, 64'h0, 64'h99999999_AAAAAAAA, 64'h0, 1,
                        {64'h0, 32'hAAAAAAAA}, {64'h4, 32'h99999999}, 64'h8));

    $display("[TB] random traffic");
    exp_pc  = 64'h8;
    occ     = 0;
    pending = 1'b0;
    lat     = 0;
    pushes  = 0;
    pend_addr = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      full        = (occ >= CAP);
      full_almost = (occ >= CAP - 1);
      drain       = (occ > 0) && ($urandom_range(0, 3) == 0);
      fetch_en    = ($urandom_range(0, 3) != 0);
      redirect_en = ($urandom_range(0, 15) == 0);
      if (redirect_en) redirect_pc = pickPc();
      imem_valid = 1'b0;
      if (pending) begin
        if (lat == 0) begin
          imem_valid = 1'b1;
          imem_data  = memLine(pend_addr);
          pending    = 1'b0;
        end else begin
          lat--;
        end
      end else if ($urandom_range(0, 7) == 0) begin
        imem_valid = 1'b1;
        imem_data  = {$urandom, $urandom};
      end
      imem_ack = imem_req && ($urandom_range(0, 2) != 0);
      #1;
      checkOutput("rand_pc", pc, exp_pc);
      if (imem_req) checkOutput("rand_addr", imem_addr, {exp_pc[63:3], 3'b000});
      if (redirect_en) checkOutput("rand_squash", {din1_en, din2_en}, 0);
      if (din1_en) begin
        checkOutput("rand_din1", din1, {exp_pc, memWord(exp_pc)});
        checkOutput("rand_en2", din2_en, !exp_pc[2]);
        if (din2_en) checkOutput("rand_din2", din2, {exp_pc + 64'd4, memWord(exp_pc + 64'd4)});
        else         checkOutput("rand_din2_zero", din2, 0);
      end else begin
        checkOutput("rand_en2_alone", din2_en, 0);
      end
      got1     = din1_en;
      got2     = din2_en;
      acked    = imem_req && imem_ack;
      req_addr = imem_addr;
      @(posedge clk);
      if (redirect_en)  exp_pc = redirect_pc;
      else if (got1)    exp_pc = exp_pc + (exp_pc[2] ? 64'd4 : 64'd8);
      if (got1) pushes++;
      occ = occ + int'(got1) + int'(got2) - int'(drain);
      checkOutput("rand_occupancy", occ <= CAP, 1);
      if (occ > CAP) occ = CAP;
      if (acked) begin
        pending   = 1'b1;
        pend_addr = req_addr;
        lat       = $urandom_range(0, 2);
      end
      @(negedge clk);
    end
    checkOutput("rand_progress", pushes > 100, 1);

    fetch_en    = 1'b0;
    redirect_en = 1'b0;
    imem_ack    = 1'b0;
    imem_valid  = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
# if_fetch

Two-wide instruction fetch stage sitting directly upstream of the instruction circular buffer (`cb`). It keeps the fetch PC and issues one aligned 64-bit line request at a time to instruction memory. It pushes the one or two returned instructions, tagged with their PCs, into the buffer through the buffer's `din1`/`din2` write ports. It throttles on the buffer's `full`/`full_almost` flags and squashes in-flight fetches on a redirect.

## Interface
- `ADDR_W`, 64: PC / address width.
- `INST_W`, 32: instruction width; two instructions per 64-bit memory line.
- `RESET_PC`, 0: PC loaded on reset.
- Buffer entry width is `ADDR_W+INST_W`, packed as {pc, inst}.
- `clk`  in  1  clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low (asserted when 0).
- `fetch_en`  in  1  permits new requests; does not cancel an outstanding one.
- `redirect_en`  in  1  branch/exception redirect, highest priority.
- `redirect_pc`  in  ADDR_W  new fetch PC, 4-byte aligned.
- `imem_req`  out  1  line request valid.
- `imem_addr`  out  ADDR_W  {pc[ADDR_W-1:3], 3'b000}.
- `imem_ack`  in  1  request accepted this cycle.
- `imem_valid`  in  1  response data valid this cycle.
- `imem_data`  in  64  [31:0] is the word at +0, [63:32] is the word at +4.
- `full`, `full_almost`  in  1 each  from the buffer.
- `din1_en`, `din2_en`  out  1 each  buffer write enables.
- `din1`, `din2`  out  ADDR_W+INST_W each  buffer write data.
- `pc`  out  ADDR_W  current fetch PC (debug).

## Operation
- States: IDLE, REQ, WAIT, PUSH. Reset → IDLE, `pc`=RESET_PC, drop flag 0, all outputs 0.
- IDLE → REQ when `fetch_en` & ~`full` & ~`full_almost`. Two free slots are guaranteed at issue. Only this stage writes the buffer, so the room persists until the push.
- REQ: `imem_req`=1. On `imem_ack` → WAIT. Otherwise hold `imem_req` and `imem_addr` stable.
- WAIT: on `imem_valid`, latch the data. If drop=0 → PUSH. If drop=1 → IDLE with drop cleared and nothing pushed.
- PUSH, for one cycle:
  - If `pc[2]`=0: `din1`={pc, data[31:0]} and `din2`={pc+4, data[63:32]}; both enables high; `pc`+=8.
  - If `pc[2]`=1: `din1`={pc, data[63:32]}; only `din1_en` high; `din2`=0; `pc`+=4.
  - Then → IDLE.
- Redirect, evaluated every cycle, overriding the normal transition; `pc`←`redirect_pc` at the edge:
  - IDLE: stay IDLE.
  - REQ without `imem_ack`: → IDLE. The request is abandoned; memory must tolerate withdrawal before ack.
  - REQ with `imem_ack`: → WAIT with drop=1.
  - WAIT without `imem_valid`: stay WAIT, drop=1.
  - WAIT with `imem_valid`: data discarded → IDLE.
  - PUSH: `din1_en`/`din2_en` forced 0 combinationally that cycle → IDLE. The `pc` increment is not applied.
- `imem_valid` in IDLE, REQ, or PUSH is ignored.
- Address arithmetic is modulo 2^ADDR_W; the PC wraps silently.

## Timing
- Outputs are Moore, decoded from registered state. The exception is `din*_en`, which is qualified by `~redirect_en`.
- Minimum pair latency: IDLE(1) + REQ(1, with same-cycle ack) + WAIT(1, with same-cycle valid) + PUSH(1) = 4 cycles per line.
- `din*_en` high for exactly one cycle per accepted response. The buffer's flags reflect the push in the following IDLE cycle.
- Reset assertion takes effect immediately (asynchronous): all outputs 0 and state IDLE within the same cycle, regardless of the current state. A response arriving after reset is ignored.
- Redirect to the first new-line request: redirect edge → IDLE, next edge → REQ. `imem_addr` shows the new line 2 cycles after `redirect_en` is sampled.

## Test plan
- Reset, `fetch_en`=1, immediate ack, valid one cycle later with 0x11111111_22222222 → `din1`={0x0, 0x22222222}, `din2`={0x4, 0x11111111}, both enables pulse once, `pc`=0x8; next `imem_addr`=0x8.
- Redirect to 0x104 from IDLE → `imem_addr`=0x100; response 0xAAAAAAAA_BBBBBBBB → only `din1_en`, with `din1`={0x104, 0xAAAAAAAA}; `pc`=0x108.
- Redirect to 0x200 while in WAIT, response two cycles later → no `din*_en`; the next request has `imem_addr`=0x200 and is pushed normally.
- `full_almost`=1 held for 5 cycles → `imem_req` stays 0. Deassert it → `imem_req`=1 on the next cycle. Repeat with `full`=1.
- `redirect_en` in the PUSH cycle → both enables 0 that cycle; `pc`=`redirect_pc`, not `pc`+8.
- `reset`=0 mid-WAIT, then `imem_valid` after release → outputs 0 immediately, `pc`=RESET_PC, late response produces no push; normal fetch resumes from RESET_PC.
